maze_vga_renderer: RTL and testbench
====================================

Name: maze_vga_renderer

Overview:
Downstream display stage of the maze game. It consumes the current maze bitmap, the maze dimensions, the player position and the running flag from the game controller. It generates 640x480@60 VGA timing and 1-bit-per-channel colour flags. It returns a once-per-frame draw-done pulse that the controller uses to pace player moves. Each maze cell is a 16x16 pixel tile on a 40x30 grid.

Parameters:
PIX_DIV, 2, i_Clk cycles per pixel tick (50 MHz -> 25 MHz)
H_ACTIVE / H_FP / H_SYNC / H_BP, 640/16/96/48, horizontal timing in pixels
V_ACTIVE / V_FP / V_SYNC / V_BP, 480/10/2/33, vertical timing in lines
GRID_W, 40, tiles per row (map row stride)
GRID_H, 30, tile rows
TILE_SHIFT, 4, log2 of tile size in pixels

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  synchronous active-low reset
i_Map  in  GRID_W*GRID_H  wall bitmap; tile (x,y) is a wall when bit [GRID_W*GRID_H-1-(y*GRID_W+x)] = 1
i_Col  in  7  active maze width in tiles
i_Row  in  6  active maze height in tiles
i_PlayerPos_X  in  7  player tile column
i_PlayerPos_Y  in  6  player tile row
i_Running  in  1  game not in IDLE
o_hSync  out  1  horizontal sync, active low
o_vSync  out  1  vertical sync, active low
o_fRed, o_fGreen, o_fBlue  out  1 each  colour flags (top replicates each to 8 bits)
o_fDrawDone  out  1  one-clock pulse per frame

Behaviour:
- Reset (i_Rst low at a clock edge; synchronous active-low, sampled only on posedge i_Clk):
  - Pixel divider, h counter and v counter go to 0.
  - o_hSync = o_vSync = 1 (inactive); o_fRed/o_fGreen/o_fBlue = 0; o_fDrawDone = 0; all shadow registers go to 0.
- Pixel tick: asserted one clock in every PIX_DIV. The counters advance only on a tick.
  - h counts 0..799 and wraps.
  - v increments when h wraps, counts 0..524 and wraps.
- Sync:
  - hSync is low for h in [656,751].
  - vSync is low for v in [490,491].
- Pipeline: sync and colour are computed from the current counters and registered on the tick. Output latency is 1 tick, and sync and colour stay aligned.
- Shadow latch: on the tick where v becomes 490 with h = 0, the block latches i_Map, i_Col, i_Row, i_PlayerPos_X/Y and i_Running. Rendering uses only these shadows, so changes mid-frame never tear.
- Tile lookup: tx = h >> TILE_SHIFT, ty = v >> TILE_SHIFT.
- Colour priority, first match wins:
  1. Outside the active area (h >= 640 or v >= 480): 000.
  2. Shadow running = 0: 000.
  3. tx >= col or ty >= row: 000.
  4. tx == player X and ty == player Y: red (100).
  5. tx == col-2 and ty == row-2 (goal tile): green (010).
  6. Map bit is 1 (wall): white (111).
  7. Otherwise (floor): 000.
- o_fDrawDone:
  - High for exactly one i_Clk cycle, on the tick where h wraps 799->0 and v goes 479->480.
  - Period is 800*525*PIX_DIV clocks (840000 with default parameters).
  - The first pulse comes 480*800*PIX_DIV clocks after reset release (768000 with default parameters).
- col/row = 0: rule 3 blanks every tile; there is no underflow hazard in rule 5.
- Reset mid-frame: everything returns to reset values on that edge; the frame restarts from h = v = 0.

Decomposition:
- Shared constants go in the team's common parameter include: VGA timing values, GRID_W/GRID_H, and 3-bit colour codes (BLACK, RED, GREEN, WHITE).
- Sub-module vga_timing owns the divider, the h/v counters, sync generation, the active-area flag, frame_end (draw-done) and the latch strobe.
- maze_vga_renderer instantiates vga_timing and holds the shadow registers, tile lookup, colour mux and output registers.

Test Plan:
- Reset held 5 clocks, then released: all outputs read reset values during reset; first o_fDrawDone at clock 768000 after release; next pulse exactly 840000 clocks later; each pulse is 1 clock wide.
- Line timing: o_hSync falls 656*2 (+1 pipeline tick) clocks after line start and stays low 192 clocks. o_vSync stays low for 2 lines (3200 clocks) per frame.
- Running=1, col=40, row=30, player (1,1), empty map: pixel (16..31, 16..31) is red; pixel (608,448), which is tile (38,28), is green; all other visible pixels are black.
- Map bit for tile (0,0) set (bit 1199): pixels (0..15, 0..15) are white. Setting i_Col=20 blanks tiles with tx >= 20, even where wall bits are set.
- Player X changed from 1 to 2 while v = 100: the current frame still draws the player at tile 1; the frame after the latch at v = 490 draws it at tile 2.
- i_Running = 0: every visible pixel is 000 while the sync signals and o_fDrawDone continue unchanged. Reset asserted at v = 300 leads to a clean frame restart from h = v = 0.

Source files
------------

// File: rtl/maze_vga_renderer_pkg.sv
// Shared constants for the maze VGA display stage: default 640x480@60 timing,
// tile grid geometry, colour codes and the wall-bitmap index helper.
package maze_vga_renderer_pkg;

  localparam int DEF_PIX_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int TILE_SHIFT = 4;
  localparam int MAP_BITS   = GRID_W * GRID_H;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] WHITE = 3'b111;

  // Tile (0,0) lives in the MSB of the bitmap, rows packed left to right.
  function automatic logic [10:0] mapIndex(input logic [5:0] tx, input logic [5:0] ty);
    return 11'(MAP_BITS - 1) - (11'(ty) * 11'(GRID_W) + 11'(tx));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider plus horizontal/vertical counters, raw sync levels,
// active-area flag, end-of-visible-frame pulse and the shadow latch strobe.
module vga_timing #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       tick,
  output logic [9:0] hCnt,
  output logic [9:0] vCnt,
  output logic       hSyncNext,
  output logic       vSyncNext,
  output logic       active,
  output logic       frameEnd,
  output logic       latchStrobe
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] divCnt;
  logic             hWrap;
  logic             vWrap;

  assign tick  = (divCnt == DIV_W'(PIX_DIV - 1));
  assign hWrap = (hCnt == 10'(H_TOTAL - 1));
  assign vWrap = (vCnt == 10'(V_TOTAL - 1));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      divCnt <= '0;
      hCnt   <= '0;
      vCnt   <= '0;
    end else begin
      divCnt <= tick ? '0 : divCnt + DIV_W'(1);
      if (tick) begin
        if (hWrap) begin
          hCnt <= '0;
          vCnt <= vWrap ? '0 : vCnt + 10'd1;
        end else begin
          hCnt <= hCnt + 10'd1;
        end
      end
    end
  end

  assign hSyncNext = !((hCnt >= 10'(H_ACTIVE + H_FP)) && (hCnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vSyncNext = !((vCnt >= 10'(V_ACTIVE + V_FP)) && (vCnt < 10'(V_ACTIVE + V_FP + V_SYNC)));
  assign active    = (hCnt < 10'(H_ACTIVE)) && (vCnt < 10'(V_ACTIVE));

  // Both strobes fire on the tick that starts a new line.
  assign frameEnd    = tick && hWrap && (vCnt == 10'(V_ACTIVE - 1));
  assign latchStrobe = tick && hWrap && (vCnt == 10'(V_ACTIVE + V_FP - 1));

endmodule

// File: rtl/maze_vga_renderer.sv
// Maze display stage: latches game state once per frame at vsync start and
// renders 16x16 tiles with player/goal/wall priority into registered VGA outputs.
module maze_vga_renderer
  import maze_vga_renderer_pkg::*;
#(
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [MAP_BITS-1:0] i_Map,
  input  logic [6:0]          i_Col,
  input  logic [5:0]          i_Row,
  input  logic [6:0]          i_PlayerPos_X,
  input  logic [5:0]          i_PlayerPos_Y,
  input  logic                i_Running,
  output logic                o_hSync,
  output logic                o_vSync,
  output logic                o_fRed,
  output logic                o_fGreen,
  output logic                o_fBlue,
  output logic                o_fDrawDone
);

  logic       tick;
  logic [9:0] hCnt;
  logic [9:0] vCnt;
  logic       hSyncNext;
  logic       vSyncNext;
  logic       active;
  logic       frameEnd;
  logic       latchStrobe;

  vga_timing #(
    .PIX_DIV (PIX_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) uTiming (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .tick       (tick),
    .hCnt       (hCnt),
    .vCnt       (vCnt),
    .hSyncNext  (hSyncNext),
    .vSyncNext  (vSyncNext),
    .active     (active),
    .frameEnd   (frameEnd),
    .latchStrobe(latchStrobe)
  );

  logic [MAP_BITS-1:0] shMap;
  logic [6:0]          shCol;
  logic [5:0]          shRow;
  logic [6:0]          shPx;
  logic [5:0]          shPy;
  logic                shRunning;

  logic [5:0] tx;
  logic [5:0] ty;
  logic       inGrid;
  logic       onPlayer;
  logic       onGoal;
  logic       wallBit;
  logic [2:0] pixColour;

  assign tx = 6'(hCnt >> TILE_SHIFT);
  assign ty = 6'(vCnt >> TILE_SHIFT);

  assign inGrid   = ({1'b0, tx} < shCol) && (ty < shRow);
  assign onPlayer = ({1'b0, tx} == shPx) && (ty == shPy);
  // Compare tx+2 against col so col/row below 2 cannot wrap onto a real tile.
  assign onGoal   = (({2'b0, tx} + 8'd2) == {1'b0, shCol}) && (({1'b0, ty} + 7'd2) == {1'b0, shRow});
  assign wallBit  = ((tx < 6'(GRID_W)) && (ty < 6'(GRID_H))) ? shMap[mapIndex(tx, ty)] : 1'b0;

  always_comb begin
    pixColour = BLACK;
    if (active && shRunning && inGrid) begin
      if (onPlayer)     pixColour = RED;
      else if (onGoal)  pixColour = GREEN;
      else if (wallBit) pixColour = WHITE;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      shMap       <= '0;
      shCol       <= '0;
      shRow       <= '0;
      shPx        <= '0;
      shPy        <= '0;
      shRunning   <= 1'b0;
      o_hSync     <= 1'b1;
      o_vSync     <= 1'b1;
      o_fRed      <= 1'b0;
      o_fGreen    <= 1'b0;
      o_fBlue     <= 1'b0;
      o_fDrawDone <= 1'b0;
    end else begin
      o_fDrawDone <= frameEnd;
      if (latchStrobe) begin
        shMap     <= i_Map;
        shCol     <= i_Col;
        shRow     <= i_Row;
        shPx      <= i_PlayerPos_X;
        shPy      <= i_PlayerPos_Y;
        shRunning <= i_Running;
      end
      if (tick) begin
        o_hSync  <= hSyncNext;
        o_vSync  <= vSyncNext;
        o_fRed   <= pixColour[2];
        o_fGreen <= pixColour[1];
        o_fBlue  <= pixColour[0];
      end
    end
  end

endmodule

// File: tb/tb_maze_vga_renderer.sv
// Directed bench for maze_vga_renderer on a reduced 80x55 raster (64x48 visible,
// 4x3 tiles) so several whole frames fit in a short run.
module tb_maze_vga_renderer;

  localparam int HT        = 80;
  localparam int VT        = 55;
  localparam int FRAME_PIX = HT * VT;
  localparam int FRAME_CLK = 2 * FRAME_PIX;
  localparam int FIRST_DONE = 48 * HT * 2;

  logic          i_Clk = 1'b0;
  logic          i_Rst = 1'b0;
  logic [1199:0] i_Map = '0;
  logic [6:0]    i_Col = 7'd4;
  logic [5:0]    i_Row = 6'd3;
  logic [6:0]    i_PlayerPos_X = 7'd1;
  logic [5:0]    i_PlayerPos_Y = 6'd1;
  logic          i_Running = 1'b1;
  logic          o_hSync, o_vSync, o_fRed, o_fGreen, o_fBlue, o_fDrawDone;

  int edgeCnt = 0;
  int testCnt = 0;
  int failCnt = 0;

  maze_vga_renderer #(
    .PIX_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Map(i_Map), .i_Col(i_Col), .i_Row(i_Row),
    .i_PlayerPos_X(i_PlayerPos_X), .i_PlayerPos_Y(i_PlayerPos_Y), .i_Running(i_Running),
    .o_hSync(o_hSync), .o_vSync(o_vSync), .o_fRed(o_fRed), .o_fGreen(o_fGreen),
    .o_fBlue(o_fBlue), .o_fDrawDone(o_fDrawDone)
  );

  always #5 i_Clk = ~i_Clk;

  // Rising edges since reset release; edge 1 is the first edge with i_Rst high.
  always @(posedge i_Clk) begin
    if (!i_Rst) edgeCnt <= 0;
    else        edgeCnt <= edgeCnt + 1;
  end

  // Pixel p of a frame is computed when the counters sit at p and shows after the tick that leaves p.
  function automatic int pixEdge(input int f, input int x, input int y);
    return 2 * (f * FRAME_PIX + y * HT + x + 1);
  endfunction

  task automatic goEdge(input int target);
    int guard = 0;
    while (edgeCnt < target && guard < 100000) begin
      @(posedge i_Clk); #1;
      guard++;
    end
    testCnt++;
    if (edgeCnt != target) begin
      failCnt++;
      $display("FAIL goEdge reached edge %0d, required %0d", edgeCnt, target);
    end
  endtask

  task automatic findDone(output int at);
    at = -1;
    for (int i = 0; i < 20000 && at < 0; i++) begin
      @(posedge i_Clk); #1;
      if (o_fDrawDone === 1'b1) at = edgeCnt;
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b0;
    repeat (5) begin
      @(posedge i_Clk); #1;
      testCnt++;
      if ({o_hSync, o_vSync, o_fRed, o_fGreen, o_fBlue, o_fDrawDone} !== 6'b110000) begin
        failCnt++;
        $display("FAIL reset_outputs got %b required 110000",
                 {o_hSync, o_vSync, o_fRed, o_fGreen, o_fBlue, o_fDrawDone});
      end
    end
    @(negedge i_Clk);
    i_Rst = 1'b1;
  endtask

  task automatic test_hsync_line0();
    int firstLow = -1;
    int lowCnt = 0;
    while (edgeCnt < 160) begin
      @(posedge i_Clk); #1;
      if (o_hSync === 1'b0) begin
        lowCnt++;
        if (firstLow < 0) firstLow = edgeCnt;
      end
    end
    testCnt++;
    if (firstLow !== 138) begin
      failCnt++;
      $display("FAIL hsync_fall at edge %0d, required 138", firstLow);
    end
    testCnt++;
    if (lowCnt !== 16) begin
      failCnt++;
      $display("FAIL hsync_width %0d clocks, required 16", lowCnt);
    end
  endtask

  task automatic test_frame0_blank();
    goEdge(pixEdge(0, 16, 16));
    testCnt++;
    if ({o_fRed, o_fGreen, o_fBlue} !== 3'b000) begin
      failCnt++;
      $display("FAIL frame0_unlatched colour %b, required 000", {o_fRed, o_fGreen, o_fBlue});
    end
  endtask

  task automatic test_draw_done(input int expAt, input string tag);
    int at;
    findDone(at);
    testCnt++;
    if (at !== expAt) begin
      failCnt++;
      $display("FAIL %s pulse at edge %0d, required %0d", tag, at, expAt);
    end
    @(posedge i_Clk); #1;
    testCnt++;
    if (o_fDrawDone !== 1'b0) begin
      failCnt++;
      $display("FAIL %s width pulse still %b one clock later, required 0", tag, o_fDrawDone);
    end
  endtask

  task automatic test_vsync();
    int firstLow = -1;
    int lowCnt = 0;
    int doneCnt = 0;
    while (edgeCnt < FRAME_CLK) begin
      @(posedge i_Clk); #1;
      if (o_fDrawDone === 1'b1) doneCnt++;
      if (o_vSync === 1'b0) begin
        lowCnt++;
        if (firstLow < 0) firstLow = edgeCnt;
      end
    end
    testCnt++;
    if (firstLow !== 8002) begin
      failCnt++;
      $display("FAIL vsync_fall at edge %0d, required 8002", firstLow);
    end
    testCnt++;
    if (lowCnt !== 320) begin
      failCnt++;
      $display("FAIL vsync_width %0d clocks, required 320", lowCnt);
    end
    testCnt++;
    if (doneCnt !== 0) begin
      failCnt++;
      $display("FAIL vsync_no_extra_done saw %0d pulses, required 0", doneCnt);
    end
  endtask

  task automatic test_render_frame1();
    int xs[12]         = '{0, 16, 48, 70, 15, 16, 32, 31, 32, 48, 16, 63};
    int ys[12]         = '{0, 0, 0, 10, 15, 16, 16, 31, 31, 32, 40, 47};
    logic [2:0] exp[12] = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b111, 3'b100,
                           3'b010, 3'b100, 3'b010, 3'b111, 3'b000, 3'b111};
    for (int i = 0; i < 12; i++) begin
      if (i == 7) i_PlayerPos_X = 7'd2;
      goEdge(pixEdge(1, xs[i], ys[i]));
      testCnt++;
      if ({o_fRed, o_fGreen, o_fBlue} !== exp[i]) begin
        failCnt++;
        $display("FAIL render_f1 pixel (%0d,%0d) colour %b, required %b",
                 xs[i], ys[i], {o_fRed, o_fGreen, o_fBlue}, exp[i]);
      end
    end
  endtask

  task automatic test_player_move();
    int xs[3]         = '{48, 16, 32};
    int ys[3]         = '{0, 16, 16};
    logic [2:0] exp[3] = '{3'b111, 3'b000, 3'b100};
    for (int i = 0; i < 3; i++) begin
      goEdge(pixEdge(2, xs[i], ys[i]));
      testCnt++;
      if ({o_fRed, o_fGreen, o_fBlue} !== exp[i]) begin
        failCnt++;
        $display("FAIL player_move pixel (%0d,%0d) colour %b, required %b",
                 xs[i], ys[i], {o_fRed, o_fGreen, o_fBlue}, exp[i]);
      end
    end
    i_Col = 7'd2;
  endtask

  task automatic test_col_blank();
    int xs[4]         = '{0, 48, 0, 32};
    int ys[4]         = '{0, 0, 16, 16};
    logic [2:0] exp[4] = '{3'b111, 3'b000, 3'b010, 3'b000};
    for (int i = 0; i < 4; i++) begin
      goEdge(pixEdge(3, xs[i], ys[i]));
      testCnt++;
      if ({o_fRed, o_fGreen, o_fBlue} !== exp[i]) begin
        failCnt++;
        $display("FAIL col_blank pixel (%0d,%0d) colour %b, required %b",
                 xs[i], ys[i], {o_fRed, o_fGreen, o_fBlue}, exp[i]);
      end
    end
    i_Running = 1'b0;
  endtask

  task automatic test_running_off();
    int hx[4]     = '{67, 68, 75, 76};
    logic hexp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    goEdge(pixEdge(4, 0, 0));
    testCnt++;
    if ({o_fRed, o_fGreen, o_fBlue} !== 3'b000) begin
      failCnt++;
      $display("FAIL idle_wall colour %b, required 000", {o_fRed, o_fGreen, o_fBlue});
    end
    for (int i = 0; i < 4; i++) begin
      goEdge(pixEdge(4, hx[i], 5));
      testCnt++;
      if (o_hSync !== hexp[i]) begin
        failCnt++;
        $display("FAIL idle_hsync h=%0d got %b, required %b", hx[i], o_hSync, hexp[i]);
      end
    end
    goEdge(pixEdge(4, 0, 16));
    testCnt++;
    if ({o_fRed, o_fGreen, o_fBlue} !== 3'b000) begin
      failCnt++;
      $display("FAIL idle_goal colour %b, required 000", {o_fRed, o_fGreen, o_fBlue});
    end
    test_draw_done(FIRST_DONE + 4 * FRAME_CLK, "idle_done");
    i_Running = 1'b1;
    goEdge(pixEdge(4, 0, 50));
    testCnt++;
    if (o_vSync !== 1'b0) begin
      failCnt++;
      $display("FAIL idle_vsync got %b, required 0", o_vSync);
    end
  endtask

  task automatic test_reset_midframe();
    goEdge(pixEdge(5, 0, 16));
    testCnt++;
    if ({o_fRed, o_fGreen, o_fBlue} !== 3'b010) begin
      failCnt++;
      $display("FAIL resume_goal colour %b, required 010", {o_fRed, o_fGreen, o_fBlue});
    end
    goEdge(pixEdge(5, 70, 30));
    testCnt++;
    if (o_hSync !== 1'b0) begin
      failCnt++;
      $display("FAIL pre_reset_hsync got %b, required 0", o_hSync);
    end
    i_Rst = 1'b0;
    @(posedge i_Clk); #1;
    testCnt++;
    if ({o_hSync, o_vSync, o_fRed, o_fGreen, o_fBlue, o_fDrawDone} !== 6'b110000) begin
      failCnt++;
      $display("FAIL midframe_reset outputs %b, required 110000",
               {o_hSync, o_vSync, o_fRed, o_fGreen, o_fBlue, o_fDrawDone});
    end
    @(negedge i_Clk);
    i_Rst = 1'b1;
    goEdge(pixEdge(0, 0, 16));
    testCnt++;
    if ({o_fRed, o_fGreen, o_fBlue} !== 3'b000) begin
      failCnt++;
      $display("FAIL restart_shadow colour %b, required 000", {o_fRed, o_fGreen, o_fBlue});
    end
    test_draw_done(FIRST_DONE, "restart_done");
    goEdge(pixEdge(1, 0, 16));
    testCnt++;
    if ({o_fRed, o_fGreen, o_fBlue} !== 3'b010) begin
      failCnt++;
      $display("FAIL restart_goal colour %b, required 010", {o_fRed, o_fGreen, o_fBlue});
    end
  endtask

  initial begin
    // Walls at tiles (0,0), (3,0), (2,1) and (3,2).
    i_Map[1199] = 1'b1;
    i_Map[1196] = 1'b1;
    i_Map[1157] = 1'b1;
    i_Map[1116] = 1'b1;
    test_reset();
    test_hsync_line0();
    test_frame0_blank();
    test_draw_done(FIRST_DONE, "first_done");
    test_vsync();
    test_render_frame1();
    test_draw_done(FIRST_DONE + FRAME_CLK, "second_done");
    test_player_move();
    test_col_blank();
    test_running_off();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
